// File: rtl/fetch_unit.sv
// fetch_unit: two-entry prefetch buffer of {pc, instr} with redirect flush and FETCH/HALTED control.
// Define FETCH_PERF_CNT_EN to add the fetch_count push counter output.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        halt_req,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        halted,
   output logic        misalign_err
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] fetch_count
`endif
);
   typedef enum logic {FETCH, HALTED} state_t;
   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [1:0]  count_q, count_d, count_p;
   logic [63:0] ent0_q, ent0_d, ent1_q, ent1_d;
   logic        misalign_q, misalign_d;
   logic        pop, push;
   // Entry 0 is the head; a pop shifts entry 1 down and a push lands at the post-pop tail.
   always_comb begin
      pop        = out_valid && out_ready;
      push       = state_q == FETCH && !redirect && !halt_req && (count_q < 2'd2 || pop);
      count_p    = count_q - {1'b0, pop};
      ent0_d     = (push && count_p == 2'd0) ? {pc_q, imem_instr} : pop ? ent1_q : ent0_q;
      ent1_d     = (push && count_p == 2'd1) ? {pc_q, imem_instr} : ent1_q;
      count_d    = redirect ? 2'd0 : count_p + {1'b0, push};
      pc_d       = redirect ? {redirect_pc[31:2], 2'b00} : push ? pc_q + 32'd4 : pc_q;
      state_d    = redirect ? FETCH : halt_req ? HALTED : state_q;
      misalign_d = misalign_q | (redirect & |redirect_pc[1:0]);
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q    <= FETCH;
         pc_q       <= RESET_PC;
         count_q    <= 2'd0;
         ent0_q     <= 64'd0;
         ent1_q     <= 64'd0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         count_q    <= count_d;
         ent0_q     <= ent0_d;
         ent1_q     <= ent1_d;
         misalign_q <= misalign_d;
      end
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count_q;
   always_ff @(posedge clk or posedge reset)
      if (reset) fetch_count_q <= 32'd0;
      else if (push) fetch_count_q <= fetch_count_q + 32'd1;
   assign fetch_count = fetch_count_q;
`endif
   assign imem_addr    = pc_q;
   assign out_valid    = count_q != 2'd0;
   assign out_pc       = ent0_q[63:32];
   assign out_instr    = ent0_q[31:0];
   assign halted       = state_q == HALTED;
   assign misalign_err = misalign_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit; a second instance with RESET_PC=FFFF_FFF8 covers PC wrap.
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] imem_addr, imem_instr, redirect_pc, out_instr, out_pc;
   logic        redirect, halt_req, out_valid, out_ready, halted, misalign_err;
   logic [31:0] w_addr, w_instr, w_instr_o, w_pc;
   logic        w_valid, w_halted, w_mis;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count, w_count;
`endif
   logic [63:0] sb[$];
   logic [31:0] mpc, mcnt;
   logic        mhalt, mmis;
   int          n_cmp = 0, n_err = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a < 32'd12 ? (32'(a[3:2]) + 32'd1) * 32'h11 : a ^ 32'h5A5A_0000;
   endfunction

   assign imem_instr = mem(imem_addr);
   assign w_instr    = mem(w_addr);

   fetch_unit dut (
      .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
      .redirect(redirect), .redirect_pc(redirect_pc), .halt_req(halt_req),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
      .halted(halted), .misalign_err(misalign_err)
`ifdef FETCH_PERF_CNT_EN
      , .fetch_count(fetch_count)
`endif
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
      .clk(clk), .reset(reset), .imem_addr(w_addr), .imem_instr(w_instr),
      .redirect(1'b0), .redirect_pc(32'd0), .halt_req(1'b0),
      .out_valid(w_valid), .out_ready(1'b1), .out_instr(w_instr_o), .out_pc(w_pc),
      .halted(w_halted), .misalign_err(w_mis)
`ifdef FETCH_PERF_CNT_EN
      , .fetch_count(w_count)
`endif
   );

   // Reference model of the main instance, advanced with the inputs present at the coming edge.
   task automatic tick();
      logic pop, push;
      pop  = sb.size() != 0 && out_ready;
      push = !mhalt && !redirect && !halt_req && (sb.size() < 2 || pop);
      if (redirect) begin
         sb.delete();
         mpc   = {redirect_pc[31:2], 2'b00};
         mmis  = mmis | (redirect_pc[1:0] != 2'b00);
         mhalt = 1'b0;
      end else begin
         if (pop) void'(sb.pop_front());
         if (push) begin
            sb.push_back({mpc, mem(mpc)});
            mpc  = mpc + 32'd4;
            mcnt = mcnt + 32'd1;
         end
         if (halt_req) mhalt = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; halt_req = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      sb.delete(); mpc = 32'd0; mcnt = 32'd0; mhalt = 1'b0; mmis = 1'b0;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; halt_req = 1'b0; out_ready = 1'b1;
      #3;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
      n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL rst_halted got=%b exp=0", halted); end
      n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL rst_mis got=%b exp=0", misalign_err); end
      n_cmp++; if (imem_addr !== 32'd0) begin n_err++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
      n_cmp++; if (w_addr !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL rst_waddr got=%h exp=fffffff8", w_addr); end
      do_reset();
   endtask

   task automatic test_stream();
      logic [31:0] exp_instr[3] = '{32'h11, 32'h22, 32'h33};
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, out_valid); end
         n_cmp++; if (out_pc !== 32'(i * 4)) begin n_err++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, out_pc, 32'(i * 4)); end
         n_cmp++; if (out_instr !== exp_instr[i]) begin n_err++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, out_instr, exp_instr[i]); end
         n_cmp++; if (sb.size() == 0 || {out_pc, out_instr} !== sb[0]) begin n_err++; $display("FAIL stream_sb[%0d] got=%h", i, {out_pc, out_instr}); end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      out_ready = 1'b0;
      repeat (5) tick();
      n_cmp++; if (out_valid !== 1'b1 || sb.size() != 2) begin n_err++; $display("FAIL bp_full valid=%b exp=1 depth=%0d", out_valid, sb.size()); end
      n_cmp++; if (imem_addr !== 32'd8) begin n_err++; $display("FAIL bp_addr got=%h exp=8", imem_addr); end
      n_cmp++; if (out_pc !== 32'd0) begin n_err++; $display("FAIL bp_head got=%h exp=0", out_pc); end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'(i * 4)) begin n_err++; $display("FAIL bp_drain[%0d] valid=%b pc=%h exp=%h", i, out_valid, out_pc, 32'(i * 4)); end
         n_cmp++; if (sb.size() == 0 || {out_pc, out_instr} !== sb[0]) begin n_err++; $display("FAIL bp_sb[%0d] got=%h", i, {out_pc, out_instr}); end
         tick();
      end
   endtask

   task automatic test_redirect();
      n_cmp++; if (out_valid !== 1'b1 || sb.size() != 2) begin n_err++; $display("FAIL rd_pre valid=%b depth=%0d exp=2", out_valid, sb.size()); end
      redirect = 1'b1; redirect_pc = 32'h40;
      tick();
      redirect = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rd_flush got=%b exp=0", out_valid); end
      n_cmp++; if (imem_addr !== 32'h40) begin n_err++; $display("FAIL rd_addr got=%h exp=40", imem_addr); end
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h40) begin n_err++; $display("FAIL rd_head valid=%b pc=%h exp=40", out_valid, out_pc); end
      n_cmp++; if (out_instr !== mem(32'h40)) begin n_err++; $display("FAIL rd_instr got=%h exp=%h", out_instr, mem(32'h40)); end
   endtask

   task automatic test_misalign();
      redirect = 1'b1; redirect_pc = 32'h42;
      tick();
      redirect = 1'b0;
      n_cmp++; if (imem_addr !== 32'h40) begin n_err++; $display("FAIL mis_addr got=%h exp=40", imem_addr); end
      n_cmp++; if (misalign_err !== 1'b1) begin n_err++; $display("FAIL mis_set got=%b exp=1", misalign_err); end
      for (int i = 0; i < 10; i++) begin
         redirect = 1'b1; redirect_pc = 32'h200 + 32'(i * 16);
         tick();
         n_cmp++; if (misalign_err !== 1'b1) begin n_err++; $display("FAIL mis_hold[%0d] got=%b exp=1", i, misalign_err); end
      end
      redirect = 1'b0;
   endtask

   task automatic test_halt();
      logic [31:0] a;
      tick();
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      a = imem_addr;
      n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_set got=%b exp=1", halted); end
      n_cmp++; if (a !== mpc) begin n_err++; $display("FAIL halt_addr got=%h exp=%h", a, mpc); end
      repeat (4) begin
         tick();
         n_cmp++; if (imem_addr !== a) begin n_err++; $display("FAIL halt_freeze got=%h exp=%h", imem_addr, a); end
      end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL halt_drain got=%b exp=0", out_valid); end
      redirect = 1'b1; redirect_pc = 32'h100;
      tick();
      redirect = 1'b0;
      n_cmp++; if (halted !== 1'b0 || imem_addr !== 32'h100) begin n_err++; $display("FAIL halt_exit halted=%b addr=%h exp=0/100", halted, imem_addr); end
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin n_err++; $display("FAIL halt_resume valid=%b pc=%h exp=100", out_valid, out_pc); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 400; i++) begin
         out_ready   = $urandom_range(0, 3) != 0;
         redirect    = $urandom_range(0, 15) == 0;
         halt_req    = $urandom_range(0, 31) == 0;
         redirect_pc = $urandom_range(0, 7) == 0 ? $urandom() : $urandom() & 32'hFFFF_FFFC;
         n_cmp++; if (out_valid !== (sb.size() != 0)) begin n_err++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, out_valid, sb.size() != 0); end
         if (sb.size() != 0) begin
            n_cmp++; if ({out_pc, out_instr} !== sb[0]) begin n_err++; $display("FAIL rnd_head[%0d] got=%h exp=%h", i, {out_pc, out_instr}, sb[0]); end
         end
         n_cmp++; if (imem_addr !== mpc) begin n_err++; $display("FAIL rnd_addr[%0d] got=%h exp=%h", i, imem_addr, mpc); end
         n_cmp++; if (halted !== mhalt || misalign_err !== mmis) begin n_err++; $display("FAIL rnd_flags[%0d] got=%b%b exp=%b%b", i, halted, misalign_err, mhalt, mmis); end
         tick();
      end
      redirect = 1'b0; halt_req = 1'b0; out_ready = 1'b1;
`ifdef FETCH_PERF_CNT_EN
      n_cmp++; if (fetch_count !== mcnt) begin n_err++; $display("FAIL rnd_count got=%0d exp=%0d", fetch_count, mcnt); end
`endif
   endtask

   task automatic test_wrap();
      logic [31:0] e;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         tick();
         e = 32'hFFFF_FFF8 + 32'(i * 4);
         n_cmp++; if (w_valid !== 1'b1 || w_pc !== e) begin n_err++; $display("FAIL wrap_pc[%0d] valid=%b pc=%h exp=%h", i, w_valid, w_pc, e); end
         n_cmp++; if (w_instr_o !== mem(e)) begin n_err++; $display("FAIL wrap_instr[%0d] got=%h exp=%h", i, w_instr_o, mem(e)); end
      end
`ifdef FETCH_PERF_CNT_EN
      n_cmp++; if (w_count !== 32'd3) begin n_err++; $display("FAIL wrap_count got=%0d exp=3", w_count); end
`endif
      redirect = 1'b1; redirect_pc = 32'h43;
      tick();
      redirect = 1'b0; halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      n_cmp++; if (halted !== 1'b1 || misalign_err !== 1'b1) begin n_err++; $display("FAIL pre_arst halted=%b mis=%b exp=1/1", halted, misalign_err); end
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      n_cmp++; if (out_valid !== 1'b0 || halted !== 1'b0 || misalign_err !== 1'b0) begin n_err++; $display("FAIL arst_flags v=%b h=%b m=%b exp=000", out_valid, halted, misalign_err); end
      n_cmp++; if (imem_addr !== 32'd0 || w_addr !== 32'hFFFF_FFF8 || w_valid !== 1'b0) begin n_err++; $display("FAIL arst_addr a=%h wa=%h wv=%b", imem_addr, w_addr, w_valid); end
`ifdef FETCH_PERF_CNT_EN
      n_cmp++; if (fetch_count !== 32'd0 || w_count !== 32'd0) begin n_err++; $display("FAIL arst_count got=%0d/%0d exp=0", fetch_count, w_count); end
`endif
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_misalign();
      test_halt();
      test_back_to_back();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
